// File: rtl/decade_pkg.sv
// Shared state encoding and BCD limits for the decade counter sequencer.
package decade_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_PAUSE = 2'b10,
    S_DONE  = 2'b11
  } state_e;

  localparam logic [3:0] BCD_MAX = 4'd9;
  localparam logic [3:0] BCD_MIN = 4'd0;

  // One BCD step with wrap in either direction.
  function automatic logic [3:0] bcd_step(input logic [3:0] d, input logic up);
    logic [3:0] r;
    if (up) r = (d >= BCD_MAX) ? BCD_MIN : d + 4'd1;
    else    r = (d == BCD_MIN) ? BCD_MAX : d - 4'd1;
    return r;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Count-tick prescaler: counts 0..DIV-1 while enabled, fires tick at DIV-1.
module tick_prescaler #(
  parameter int DIV = 100000000,
  parameter int CW  = 27
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic zero,
  output logic tick
);

  localparam logic [CW-1:0] TOP = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Holding the count when en drops is what lets a paused tick resume on time.
  always_comb begin
    tick  = en && (cnt_q == TOP);
    cnt_d = cnt_q;
    if (zero || tick) cnt_d = '0;
    else if (en)      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/decade_counter_ctrl.sv
// Run/pause/clear/load sequencer for one BCD digit, with carry for cascading.
module decade_counter_ctrl #(
  parameter int DIV = 100000000,
  parameter int CW  = 27
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  input  logic       stop_i,
  input  logic       clear_i,
  input  logic       load_i,
  input  logic [3:0] load_val_i,
  input  logic       up_i,
  input  logic       oneshot_i,
  output logic [3:0] digit_o,
  output logic       tick_o,
  output logic       carry_o,
  output logic       running_o,
  output logic [1:0] state_o,
  output logic       err_o
);

  import decade_pkg::*;

  state_e     state_q, state_d;
  logic [3:0] digit_q, digit_d;
  logic       tick_q, tick_d;
  logic       carry_q, carry_d;
  logic       err_q, err_d;

  logic       cmd_clear, cmd_load, cmd_stop, cmd_start;
  logic       load_ok, pre_en, pre_zero, pre_tick;
  logic [3:0] term;

  // Priority clear > load > stop > start; losers are simply dropped.
  assign cmd_clear = clear_i;
  assign cmd_load  = load_i & ~clear_i;
  assign cmd_stop  = stop_i & ~clear_i & ~load_i;
  assign cmd_start = start_i & ~clear_i & ~load_i & ~stop_i;

  assign load_ok  = (load_val_i <= BCD_MAX) && (state_q != S_RUN);
  assign pre_en   = (state_q == S_RUN) && !cmd_clear && !cmd_stop;
  assign pre_zero = cmd_clear ||
                    (cmd_start && (state_q == S_IDLE || state_q == S_DONE));

  tick_prescaler #(.DIV(DIV), .CW(CW)) u_pre (
    .clk  (clk),
    .rst  (rst),
    .en   (pre_en),
    .zero (pre_zero),
    .tick (pre_tick)
  );

  always_comb begin
    state_d = state_q;
    digit_d = digit_q;
    tick_d  = pre_tick;
    carry_d = 1'b0;
    err_d   = 1'b0;
    term    = up_i ? BCD_MAX : BCD_MIN;

    if (pre_tick) begin
      if (oneshot_i && digit_q == term) begin
        // Already parked on the terminal value: settle in DONE without a carry.
        state_d = S_DONE;
      end else begin
        digit_d = bcd_step(digit_q, up_i);
        carry_d = (digit_q == term);
        if (oneshot_i && digit_d == term) begin
          state_d = S_DONE;
          carry_d = 1'b1;
        end
      end
    end

    if (cmd_clear) begin
      state_d = S_IDLE;
      digit_d = BCD_MIN;
    end else if (cmd_load) begin
      if (!load_ok) begin
        err_d = 1'b1;
      end else begin
        digit_d = load_val_i;
        if (state_q == S_DONE) state_d = S_IDLE;
      end
    end else if (cmd_stop) begin
      if (state_q == S_RUN) state_d = S_PAUSE;
    end else if (cmd_start) begin
      if (state_q != S_RUN) state_d = S_RUN;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      digit_q <= BCD_MIN;
      tick_q  <= 1'b0;
      carry_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      digit_q <= digit_d;
      tick_q  <= tick_d;
      carry_q <= carry_d;
      err_q   <= err_d;
    end
  end

  assign digit_o   = digit_q;
  assign tick_o    = tick_q;
  assign carry_o   = carry_q;
  assign err_o     = err_q;
  assign state_o   = state_q;
  assign running_o = (state_q == S_RUN);

endmodule

// File: tb/tb_decade_counter_ctrl.sv
// Bench for decade_counter_ctrl: integer reference model plus directed literal checks.
module tb_decade_counter_ctrl;

  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_i = 1'b0, stop_i = 1'b0, clear_i = 1'b0, load_i = 1'b0;
  logic [3:0] load_val_i = 4'd0;
  logic       up_i = 1'b1, oneshot_i = 1'b0;
  logic [3:0] digit_o;
  logic       tick_o, carry_o, running_o, err_o;
  logic [1:0] state_o;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  decade_counter_ctrl #(.DIV(DIV), .CW(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
    .stop_i     (stop_i),
    .clear_i    (clear_i),
    .load_i     (load_i),
    .load_val_i (load_val_i),
    .up_i       (up_i),
    .oneshot_i  (oneshot_i),
    .digit_o    (digit_o),
    .tick_o     (tick_o),
    .carry_o    (carry_o),
    .running_o  (running_o),
    .state_o    (state_o),
    .err_o      (err_o)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Reference model: states 0 idle, 1 run, 2 pause, 3 done; digit as a plain integer.
  int m_digit = 0, m_state = 0, m_pre = 0, s0, term, nd;
  bit m_tick = 0, m_carry = 0, m_err = 0, counting;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_digit = 0; m_state = 0; m_pre = 0;
      m_tick = 0; m_carry = 0; m_err = 0;
    end else begin
      s0 = m_state;
      m_tick = 0; m_carry = 0; m_err = 0;
      counting = (s0 == 1) && !clear_i && (load_i || !stop_i);
      if (counting) begin
        if (m_pre == DIV - 1) begin
          m_pre = 0;
          m_tick = 1;
          term = up_i ? 9 : 0;
          if (oneshot_i && m_digit == term) m_state = 3;
          else begin
            nd = up_i ? (m_digit + 1) % 10 : (m_digit + 9) % 10;
            if (oneshot_i && nd == term) begin m_state = 3; m_carry = 1; end
            else if (!oneshot_i && m_digit == term) m_carry = 1;
            m_digit = nd;
          end
        end else m_pre++;
      end
      if (clear_i) begin
        m_digit = 0; m_state = 0; m_pre = 0;
      end else if (load_i) begin
        if (s0 == 1 || load_val_i > 9) m_err = 1;
        else begin
          m_digit = int'(load_val_i);
          if (s0 == 3) m_state = 0;
        end
      end else if (stop_i) begin
        if (s0 == 1) m_state = 2;
      end else if (start_i) begin
        if (s0 == 0 || s0 == 3) begin m_state = 1; m_pre = 0; end
        else if (s0 == 2) m_state = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_digit",   digit_o,   m_digit);
      chk("m_state",   state_o,   m_state);
      chk("m_running", running_o, m_state == 1);
      chk("m_tick",    tick_o,    m_tick);
      chk("m_carry",   carry_o,   m_carry);
      chk("m_err",     err_o,     m_err);
      chk("m_digit_range", digit_o <= 4'd9, 1);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic cmd(input bit c, input bit l, input bit sp, input bit st, input logic [3:0] v);
    clear_i = c; load_i = l; stop_i = sp; start_i = st; load_val_i = v;
    cyc(1);
    clear_i = 0; load_i = 0; stop_i = 0; start_i = 0;
  endtask

  initial begin
    @(posedge clk);
    chk_en = 1'b1;
    cyc(1);
    rst = 1'b0;
    chk("rst_digit", digit_o, 0);
    chk("rst_state", state_o, 0);
    chk("rst_pulses", {tick_o, carry_o, err_o, running_o}, 0);

    // Wrapping up-count through 9 -> 0
    up_i = 1; oneshot_i = 0;
    cmd(0, 0, 0, 1, 0);
    cyc(4);
    chk("t1_tick", tick_o, 1);
    chk("t1_digit", digit_o, 1);
    for (int n = 2; n <= 10; n++) begin
      cyc(4);
      chk("t1_digit_seq", digit_o, n % 10);
      chk("t1_carry", carry_o, n == 10);
    end

    // Load 7 and count down through 0 -> 9
    up_i = 0;
    cmd(1, 0, 0, 0, 0);
    cmd(0, 1, 0, 0, 4'd7);
    chk("t2_load", digit_o, 7);
    cmd(0, 0, 0, 1, 0);
    for (int n = 1; n <= 8; n++) begin
      cyc(4);
      chk("t2_digit_seq", digit_o, (n <= 7) ? 7 - n : 9);
      chk("t2_carry", carry_o, n == 8);
    end

    // Pause with prescaler at 2; resume needs two RUN cycles
    cyc(2);
    cmd(0, 0, 1, 0, 0);
    chk("t3_paused", state_o, 2);
    cyc(10);
    chk("t3_hold_digit", digit_o, 9);
    cmd(0, 0, 0, 1, 0);
    chk("t3_resume_state", state_o, 1);
    cyc(1);
    chk("t3_no_tick_yet", tick_o, 0);
    cyc(1);
    chk("t3_tick", tick_o, 1);
    chk("t3_digit", digit_o, 8);

    // One-shot up from 8
    up_i = 1; oneshot_i = 1;
    cmd(1, 0, 0, 0, 0);
    cmd(0, 1, 0, 0, 4'd8);
    cmd(0, 0, 0, 1, 0);
    cyc(4);
    chk("t4_digit", digit_o, 9);
    chk("t4_done", state_o, 3);
    chk("t4_carry", carry_o, 1);
    cyc(20);
    chk("t4_hold", digit_o, 9);
    chk("t4_still_done", state_o, 3);
    cmd(0, 0, 0, 1, 0);
    chk("t4_rerun", state_o, 1);
    cyc(4);
    chk("t4_retick", tick_o, 1);
    chk("t4_redone", state_o, 3);
    chk("t4_nocarry", carry_o, 0);
    chk("t4_redigit", digit_o, 9);

    // Load rejection in PAUSE (bad value) and in RUN
    oneshot_i = 0;
    cmd(1, 0, 0, 0, 0);
    cmd(0, 0, 0, 1, 0);
    cyc(2);
    cmd(0, 0, 1, 0, 0);
    cmd(0, 1, 0, 0, 4'd12);
    chk("t5_err_bad", err_o, 1);
    chk("t5_digit_kept", digit_o, 0);
    chk("t5_state_pause", state_o, 2);
    cmd(0, 1, 0, 0, 4'd3);
    chk("t5_pause_load", digit_o, 3);
    chk("t5_no_err", err_o, 0);
    cmd(0, 0, 0, 1, 0);
    cmd(0, 1, 0, 0, 4'd5);
    chk("t5_err_run", err_o, 1);
    chk("t5_state_run", state_o, 1);
    chk("t5_digit_run", digit_o, 3);

    // Prescaler now at DIV-1: stop in the tick cycle, tick fires right after resume
    cmd(0, 0, 1, 0, 0);
    chk("t6_stop_notick", tick_o, 0);
    chk("t6_stop_digit", digit_o, 3);
    cmd(0, 0, 0, 1, 0);
    chk("t6_resume_notick", tick_o, 0);
    cyc(1);
    chk("t6_resume_tick", tick_o, 1);
    chk("t6_resume_digit", digit_o, 4);

    // Clear plus stop in the tick cycle
    cyc(3);
    cmd(1, 0, 1, 0, 0);
    chk("t6_clr_digit", digit_o, 0);
    chk("t6_clr_state", state_o, 0);
    chk("t6_clr_pulses", {tick_o, carry_o}, 0);

    // Asynchronous reset mid-RUN, right after a tick
    cmd(0, 0, 0, 1, 0);
    cyc(4);
    chk("t6_pre_rst", digit_o, 1);
    rst = 1'b1;
    #1;
    chk("t6_rst_digit", digit_o, 0);
    chk("t6_rst_state", state_o, 0);
    chk("t6_rst_pulses", {tick_o, carry_o, err_o, running_o}, 0);
    cyc(2);
    rst = 1'b0;
    cyc(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/decade_counter_ctrl.md
Name: decade_counter_ctrl

Overview:
Run/pause/clear/load sequencer for a single BCD decade digit on the Zedboard fabric clock.
- Contains its own tick prescaler, which replaces the free-running 1 s divider.
- Gates digit advance by a state machine; supports up/down and wrap/one-shot modes.
- Emits a carry/borrow pulse so digits can be cascaded into multi-digit displays.
- Sits between debounced push-button/switch logic (upstream) and the LED/7-segment drivers (downstream).

Parameters:
DIV, 100000000, clock cycles per count tick (1 s at 100 MHz); must be >= 2; simulation uses 4.
CW, 27, prescaler counter width; must satisfy 2^CW >= DIV.

Ports:
clk  in  1  fabric clock; all logic on the rising edge.
rst  in  1  asynchronous, active-high reset.
start_i  in  1  single-cycle pulse: begin or resume counting.
stop_i  in  1  single-cycle pulse: pause counting.
clear_i  in  1  single-cycle pulse: digit to 0, return to IDLE.
load_i  in  1  single-cycle pulse: load load_val_i into the digit.
load_val_i  in  4  BCD preset value; legal range 0..9.
up_i  in  1  count direction: 1 = up, 0 = down; sampled on each tick.
oneshot_i  in  1  1 = stop at terminal value; 0 = wrap; sampled on each tick.
digit_o  out  4  current BCD digit (A..D ordering: bit0 = LSB).
tick_o  out  1  one-cycle pulse on each applied count tick.
carry_o  out  1  one-cycle pulse on 9->0 (up) or 0->9 (down), or on reaching the terminal value in one-shot.
running_o  out  1  high while in RUN.
state_o  out  2  state encoding (IDLE = 00, RUN = 01, PAUSE = 10, DONE = 11).
err_o  out  1  one-cycle pulse when a load is rejected.

Behaviour:
Reset (asynchronous, rst = 1):
- digit_o = 0, state = IDLE, prescaler = 0.
- tick_o, carry_o, err_o, running_o = 0.

Command priority per cycle: clear_i > load_i > stop_i > start_i. Lower-priority commands in the same cycle are dropped.

Prescaler:
- Counts 0..DIV-1, and only while in RUN.
- A tick occurs in the cycle where the prescaler equals DIV-1 and no stop/clear is present. The prescaler then returns to 0.
- The prescaler holds its value in PAUSE.
- It is zeroed on clear, on any IDLE or DONE -> RUN transition, and on reset.

Tick application (registered; digit_o, tick_o and carry_o update on the edge after the tick condition):
- up_i = 1: digit + 1; 9 -> 0 with carry_o = 1.
- up_i = 0: digit - 1; 0 -> 9 with carry_o = 1.
- oneshot_i = 1 and the new digit equals the terminal value (9 when up, 0 when down): state goes to DONE, carry_o = 1, no wrap.
- oneshot_i = 1 and the digit already equals the terminal value when a tick occurs: no change to the digit, state goes to DONE, carry_o = 0.

States:
- IDLE:
  - start -> RUN.
  - load -> stays IDLE, digit loaded.
  - stop -> ignored.
- RUN:
  - stop -> PAUSE.
  - clear -> IDLE.
  - load -> ignored, err_o = 1, state unchanged.
  - start -> ignored.
- PAUSE:
  - start -> RUN; prescaler resumes from its held value.
  - load -> stays PAUSE, digit loaded.
  - clear -> IDLE.
- DONE:
  - start -> RUN from the current digit; prescaler zeroed. In one-shot, the next tick therefore re-evaluates the terminal value.
  - load -> IDLE, digit loaded.
  - clear -> IDLE.

Loads: load_val_i > 9 is rejected. The digit is unchanged, err_o pulses, and the state is unchanged.

Simultaneous events:
- clear in a tick cycle: clear wins, no tick_o, no carry_o.
- stop in a tick cycle: tick suppressed, prescaler holds DIV-1. The tick fires in the first RUN cycle after resume.

Mid-operation reset: immediate return to the reset values; no pulse is emitted.

Invariant: digit_o is always within 0..9.

Decomposition:
Shared package decade_pkg holds:
- state localparams S_IDLE/S_RUN/S_PAUSE/S_DONE.
- BCD_MAX = 4'd9, BCD_MIN = 4'd0.

One sub-module, tick_prescaler (parameters DIV and CW):
- Inputs: en, zero.
- Output: tick.
- Owns the counter and the DIV-1 compare.

Test Plan:
1. DIV = 4, up_i = 1, oneshot_i = 0; start after reset -> tick_o every 4 cycles; digit 0,1,...,9,0; carry_o pulses once, coincident with the 9->0 edge.
2. Load 7 in IDLE, up_i = 0, start -> digit 6,5,...,0; after 7 ticks digit = 0; next tick digit = 9 with carry_o = 1.
3. Pause mid-count: stop on prescaler = 2, wait 10 cycles, start -> digit unchanged during PAUSE; next tick arrives 2 RUN cycles after resume.
4. oneshot_i = 1, load 8, up_i = 1, start -> one tick to 9; state_o = 11, carry_o = 1; digit holds 9 for 20 cycles; start -> next tick re-enters DONE with digit 9, carry_o = 0.
5. load_val_i = 12 in PAUSE -> err_o pulses, digit unchanged; load_i in RUN -> err_o pulses, state stays RUN.
6. clear and stop asserted in the tick cycle -> digit 0, IDLE, no tick_o/carry_o; rst asserted mid-RUN -> all outputs zero asynchronously, before the next clk edge.
